// File: rtl/unit_issue_queue_if.sv
// Purpose: bundle of command, issue, result-capture and result-read signals
//          around unit_issue_queue.
// Signals:
//   command  : cmd_wr, cmd_a, cmd_b, cmd_op -> queue ; cmd_full <- queue
//   issue    : valid, a, b, op <- queue     ; pop -> queue
//   capture  : ready <- queue               ; push, result -> queue
//   drain    : res_rd -> queue              ; res_data, res_empty <- queue
//   status   : err <- queue
// Modports:
//   master : sequencer / unit / result consumer side (drives the queue)
//   slave  : the issue queue itself
interface unit_issue_queue_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned OP_BITS = 1
);

  logic               cmd_wr;
  logic [WIDTH-1:0]   cmd_a;
  logic [WIDTH-1:0]   cmd_b;
  logic [OP_BITS-1:0] cmd_op;
  logic               cmd_full;

  logic               valid;
  logic               pop;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [OP_BITS-1:0] op;

  logic               ready;
  logic               push;
  logic [WIDTH-1:0]   result;

  logic               res_rd;
  logic [WIDTH-1:0]   res_data;
  logic               res_empty;

  logic               err;

  modport master (
    output cmd_wr, cmd_a, cmd_b, cmd_op,
    input  cmd_full,
    input  valid, a, b, op,
    output pop,
    input  ready,
    output push, result,
    output res_rd,
    input  res_data, res_empty,
    input  err
  );

  modport slave (
    input  cmd_wr, cmd_a, cmd_b, cmd_op,
    output cmd_full,
    output valid, a, b, op,
    input  pop,
    output ready,
    input  push, result,
    input  res_rd,
    output res_data, res_empty,
    output err
  );

endinterface

// File: rtl/unit_issue_queue.sv
// Purpose: initiator side of an execution-unit valid/pop + ready/push
//          handshake. Commands are buffered in a FIFO and offered to the unit
//          only while a result slot is reserved for them, so the unit's
//          results are never refused; results are buffered in a second FIFO
//          that downstream logic drains.
// Ports:
//   clk  : clock
//   rst  : asynchronous reset, active-high (the unit shares it)
//   bus  : unit_issue_queue_if.slave (command, issue, capture, drain, err)
module unit_issue_queue #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned OP_BITS   = 1,
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned RES_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  unit_issue_queue_if.slave    bus
);

  localparam int unsigned CMD_AW = $clog2(CMD_DEPTH);
  localparam int unsigned RES_AW = $clog2(RES_DEPTH);
  localparam int unsigned CNT_W  = RES_AW + 1;

  typedef struct packed {
    logic [OP_BITS-1:0] op;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   a;
  } cmd_t;

  // Storage and pointers (pointers carry one extra wrap bit)
  cmd_t             r_cmd_mem [CMD_DEPTH];
  logic [WIDTH-1:0] r_res_mem [RES_DEPTH];
  logic [CMD_AW:0]  r_cmd_wp;
  logic [CMD_AW:0]  r_cmd_rp;
  logic [RES_AW:0]  r_res_wp;
  logic [RES_AW:0]  r_res_rp;
  logic [CNT_W-1:0] r_outstanding;
  logic             r_err;

  logic [CMD_AW:0]  w_cmd_count;
  logic             w_cmd_empty;
  logic             w_cmd_full;
  logic [RES_AW:0]  w_res_count;
  logic             w_res_empty;
  logic             w_res_full;
  logic [CNT_W:0]   w_inflight;
  logic             w_credit_ok;
  logic             w_valid;
  logic             w_ready;
  logic             w_write;
  logic             w_issue;
  logic             w_capture;
  logic             w_read;
  logic             w_err_set;
  logic [CNT_W-1:0] w_out_next;
  cmd_t             w_cmd_in;
  cmd_t             w_cmd_head;

  // Occupancy derived from registered pointers only
  assign w_cmd_count = r_cmd_wp - r_cmd_rp;
  assign w_cmd_empty = (r_cmd_wp == r_cmd_rp);
  assign w_cmd_full  = (w_cmd_count == (CMD_AW+1)'(CMD_DEPTH));
  assign w_res_count = r_res_wp - r_res_rp;
  assign w_res_empty = (r_res_wp == r_res_rp);
  assign w_res_full  = (w_res_count == (RES_AW+1)'(RES_DEPTH));

  // Reservation rule: in-flight plus buffered results must leave a free slot
  assign w_inflight  = (CNT_W+1)'(r_outstanding) + (CNT_W+1)'(w_res_count);
  assign w_credit_ok = (w_inflight < (CNT_W+1)'(RES_DEPTH));

  assign w_valid   = !w_cmd_empty && w_credit_ok;
  assign w_ready   = !w_res_full;
  assign w_write   = bus.cmd_wr && !w_cmd_full;
  assign w_issue   = w_valid && bus.pop;
  assign w_capture = bus.push && w_ready;
  assign w_read    = bus.res_rd && !w_res_empty;

  assign w_cmd_in   = '{op: bus.cmd_op, b: bus.cmd_b, a: bus.cmd_a};
  assign w_cmd_head = r_cmd_mem[r_cmd_rp[CMD_AW-1:0]];

  // Protocol violations: pop with nothing offered, push refused, or an
  // unsolicited result (captured anyway)
  assign w_err_set = (bus.pop && !w_valid)
                   || (bus.push && !w_ready)
                   || (w_capture && (r_outstanding == '0));

  // Outstanding count: issue and capture together cancel; never below zero
  always_comb begin
    w_out_next = r_outstanding;
    if (w_issue && !w_capture) begin
      w_out_next = r_outstanding + CNT_W'(1);
    end else if (w_capture && !w_issue && (r_outstanding != '0)) begin
      w_out_next = r_outstanding - CNT_W'(1);
    end
  end

  // Control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_wp      <= '0;
      r_cmd_rp      <= '0;
      r_res_wp      <= '0;
      r_res_rp      <= '0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      if (w_write)   r_cmd_wp <= r_cmd_wp + (CMD_AW+1)'(1);
      if (w_issue)   r_cmd_rp <= r_cmd_rp + (CMD_AW+1)'(1);
      if (w_capture) r_res_wp <= r_res_wp + (RES_AW+1)'(1);
      if (w_read)    r_res_rp <= r_res_rp + (RES_AW+1)'(1);
      r_outstanding <= w_out_next;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  // Entry storage; contents behind the pointers need no reset
  always_ff @(posedge clk) begin
    if (w_write)   r_cmd_mem[r_cmd_wp[CMD_AW-1:0]] <= w_cmd_in;
    if (w_capture) r_res_mem[r_res_wp[RES_AW-1:0]] <= bus.result;
  end

  // Outputs are forced to zero whenever they are not meaningful
  assign bus.cmd_full  = w_cmd_full;
  assign bus.valid     = w_valid;
  assign bus.a         = w_valid ? w_cmd_head.a  : '0;
  assign bus.b         = w_valid ? w_cmd_head.b  : '0;
  assign bus.op        = w_valid ? w_cmd_head.op : '0;
  assign bus.ready     = w_ready;
  assign bus.res_empty = w_res_empty;
  assign bus.res_data  = w_res_empty ? '0 : r_res_mem[r_res_rp[RES_AW-1:0]];
  assign bus.err       = r_err;

endmodule

// File: tb/tb_unit_issue_queue.sv
// Bench for unit_issue_queue: directed stimulus, a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_unit_issue_queue;

  localparam int unsigned W   = 32;
  localparam int unsigned OPB = 1;
  localparam int unsigned CD  = 4;
  localparam int unsigned RD  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  unit_issue_queue_if #(.WIDTH(W), .OP_BITS(OPB)) u_if ();

  unit_issue_queue #(
    .WIDTH(W), .OP_BITS(OPB), .CMD_DEPTH(CD), .RES_DEPTH(RD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [OPB-1:0] op;
  } cmd_s;

  // Reference model state
  cmd_s         mq[$];
  logic [W-1:0] mres[$];
  int unsigned  m_out;
  logic         m_err;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    mres.delete();
    m_out = 0;
    m_err = 1'b0;
  endtask

  // Compare DUT outputs with the model, then advance the model by one edge
  task automatic model_step();
    logic ev, rdy, issue, cap, wr, rd;
    cmd_s c;
    ev  = (mq.size() != 0) && ((m_out + mres.size()) < RD);
    rdy = (mres.size() < RD);
    chk("m_valid",     64'(u_if.valid),     64'(ev));
    chk("m_a",         64'(u_if.a),         ev ? 64'(mq[0].a)  : 64'd0);
    chk("m_b",         64'(u_if.b),         ev ? 64'(mq[0].b)  : 64'd0);
    chk("m_op",        64'(u_if.op),        ev ? 64'(mq[0].op) : 64'd0);
    chk("m_cmd_full",  64'(u_if.cmd_full),  64'(mq.size() == CD));
    chk("m_ready",     64'(u_if.ready),     64'(rdy));
    chk("m_res_empty", 64'(u_if.res_empty), 64'(mres.size() == 0));
    chk("m_res_data",  64'(u_if.res_data),  (mres.size() != 0) ? 64'(mres[0]) : 64'd0);
    chk("m_err",       64'(u_if.err),       64'(m_err));

    issue = ev && u_if.pop;
    cap   = u_if.push && rdy;
    wr    = u_if.cmd_wr && (mq.size() < CD);
    rd    = u_if.res_rd && (mres.size() != 0);
    if ((u_if.pop && !ev) || (u_if.push && !rdy) || (cap && m_out == 0)) m_err = 1'b1;
    if (issue && !cap) m_out++;
    else if (cap && !issue && m_out > 0) m_out--;
    if (issue) void'(mq.pop_front());
    if (wr) begin
      c.a = u_if.cmd_a; c.b = u_if.cmd_b; c.op = u_if.cmd_op;
      mq.push_back(c);
    end
    if (rd)  void'(mres.pop_front());
    if (cap) mres.push_back(u_if.result);
  endtask

  // One clock cycle of stimulus; returns #1 after the active edge
  task automatic cyc(input logic wr, input logic [W-1:0] ca, input logic [W-1:0] cb,
                     input logic [OPB-1:0] cop, input logic p, input logic ps,
                     input logic [W-1:0] r, input logic rd);
    u_if.cmd_wr = wr; u_if.cmd_a = ca; u_if.cmd_b = cb; u_if.cmd_op = cop;
    u_if.pop = p; u_if.push = ps; u_if.result = r; u_if.res_rd = rd;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    u_if.cmd_wr = 1'b0; u_if.cmd_a = '0; u_if.cmd_b = '0; u_if.cmd_op = '0;
    u_if.pop = 1'b0; u_if.push = 1'b0; u_if.result = '0; u_if.res_rd = 1'b0;
  endtask

  task automatic wr_cmd(input logic [W-1:0] ca, input logic [W-1:0] cb, input logic [OPB-1:0] cop);
    cyc(1'b1, ca, cb, cop, 1'b0, 1'b0, '0, 1'b0);
  endtask
  task automatic do_pop();            cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, '0, 1'b0); endtask
  task automatic do_push(input logic [W-1:0] r); cyc(1'b0, '0, '0, '0, 1'b0, 1'b1, r, 1'b0); endtask
  task automatic do_rd();             cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b1); endtask
  task automatic idle();              cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0); endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    u_if.cmd_wr = 1'b0; u_if.cmd_a = '0; u_if.cmd_b = '0; u_if.cmd_op = '0;
    u_if.pop = 1'b0; u_if.push = 1'b0; u_if.result = '0; u_if.res_rd = 1'b0;
    model_clear();
    do_reset();

    // Reset values
    chk("rst_valid",     64'(u_if.valid),     64'd0);
    chk("rst_a",         64'(u_if.a),         64'd0);
    chk("rst_cmd_full",  64'(u_if.cmd_full),  64'd0);
    chk("rst_ready",     64'(u_if.ready),     64'd1);
    chk("rst_res_empty", 64'(u_if.res_empty), 64'd1);
    chk("rst_res_data",  64'(u_if.res_data),  64'd0);
    chk("rst_err",       64'(u_if.err),       64'd0);

    // Single command round trip
    wr_cmd(32'd100, 32'd7, 1'b0);
    chk("t1_valid", 64'(u_if.valid), 64'd1);
    chk("t1_a",     64'(u_if.a),     64'd100);
    chk("t1_b",     64'(u_if.b),     64'd7);
    idle();
    chk("t1_hold_valid", 64'(u_if.valid), 64'd1);
    do_pop();
    chk("t1_after_pop_valid", 64'(u_if.valid), 64'd0);
    do_push(32'd14);
    chk("t1_res_empty", 64'(u_if.res_empty), 64'd0);
    chk("t1_res_data",  64'(u_if.res_data),  64'd14);
    do_rd();
    chk("t1_res_empty_after_rd", 64'(u_if.res_empty), 64'd1);
    chk("t1_err", 64'(u_if.err), 64'd0);

    // Fill command FIFO, overflow write dropped, issue in order
    for (int i = 0; i < 5; i++) begin
      wr_cmd(32'(10 + i), 32'(i), 1'b0);
      if (i == 3) chk("t2_full_after_4", 64'(u_if.cmd_full), 64'd1);
    end
    chk("t2_full_after_5", 64'(u_if.cmd_full), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t2_issue_valid", 64'(u_if.valid), 64'd1);
      chk("t2_issue_a",     64'(u_if.a),     64'(10 + i));
      do_pop();
    end
    chk("t2_drained_valid", 64'(u_if.valid),    64'd0);
    chk("t2_drained_full",  64'(u_if.cmd_full), 64'd0);
    chk("t2_err",           64'(u_if.err),      64'd0);
    do_reset();

    // Credit limit
    for (int i = 0; i < 4; i++) wr_cmd(32'(20 + i), 32'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("t3_issue_a", 64'(u_if.a), 64'(20 + i));
      do_pop();
    end
    wr_cmd(32'd30, 32'd2, 1'b1);
    wr_cmd(32'd31, 32'd3, 1'b0);
    for (int i = 0; i < 4; i++) do_push(32'(200 + i));
    chk("t3_blocked_valid", 64'(u_if.valid),    64'd0);
    chk("t3_blocked_a",     64'(u_if.a),        64'd0);
    chk("t3_ready_low",     64'(u_if.ready),    64'd0);
    chk("t3_res_head",      64'(u_if.res_data), 64'd200);
    chk("t3_err_clean",     64'(u_if.err),      64'd0);
    // Push into a full result FIFO with a simultaneous read: push lost, err set
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1, 32'd999, 1'b1);
    chk("t3_valid_after_rd", 64'(u_if.valid),    64'd1);
    chk("t3_a_after_rd",     64'(u_if.a),        64'd30);
    chk("t3_op_after_rd",    64'(u_if.op),       64'd1);
    chk("t3_res_head2",      64'(u_if.res_data), 64'd201);
    chk("t3_err_drop",       64'(u_if.err),      64'd1);
    do_reset();

    // Back-to-back issue with steady occupancy of 2
    wr_cmd(32'd40, 32'd0, 1'b0);
    wr_cmd(32'd41, 32'd0, 1'b0);
    chk("t4_head", 64'(u_if.a), 64'd40);
    cyc(1'b1, 32'd42, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      chk("t4_valid", 64'(u_if.valid), 64'd1);
      chk("t4_a",     64'(u_if.a),     64'(41 + k));
      cyc(1'b1, 32'(43 + k), '0, '0, 1'b1, 1'b1, 32'(500 + k), 1'b1);
    end
    chk("t4_a_end",     64'(u_if.a),        64'd47);
    chk("t4_full_end",  64'(u_if.cmd_full), 64'd0);
    chk("t4_res_end",   64'(u_if.res_data), 64'd505);
    chk("t4_err_end",   64'(u_if.err),      64'd0);
    do_reset();

    // Errors: pop with nothing offered
    do_pop();
    chk("t5_pop_err",   64'(u_if.err),      64'd1);
    chk("t5_pop_valid", 64'(u_if.valid),    64'd0);
    chk("t5_pop_full",  64'(u_if.cmd_full), 64'd0);
    do_reset();
    // Errors: unsolicited push still captured
    do_push(32'd5);
    chk("t5_push_data",  64'(u_if.res_data),  64'd5);
    chk("t5_push_empty", 64'(u_if.res_empty), 64'd0);
    chk("t5_push_err",   64'(u_if.err),       64'd1);
    do_reset();

    // Reset in the middle of operation
    for (int i = 0; i < 4; i++) wr_cmd(32'(60 + i), 32'd9, 1'b0);
    do_pop();
    do_pop();
    do_push(32'd7);
    chk("t6_pre_valid", 64'(u_if.valid), 64'd1);
    chk("t6_pre_a",     64'(u_if.a),     64'd62);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid",     64'(u_if.valid),     64'd0);
    chk("t6_rst_res_empty", 64'(u_if.res_empty), 64'd1);
    chk("t6_rst_cmd_full",  64'(u_if.cmd_full),  64'd0);
    chk("t6_rst_err",       64'(u_if.err),       64'd0);
    chk("t6_rst_res_data",  64'(u_if.res_data),  64'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_cmd(32'd77, 32'd8, 1'b1);
    chk("t6_new_valid", 64'(u_if.valid), 64'd1);
    chk("t6_new_a",     64'(u_if.a),     64'd77);
    chk("t6_new_op",    64'(u_if.op),    64'd1);
    do_pop();
    chk("t6_new_popped", 64'(u_if.valid), 64'd0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
